// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and channel constants for the TDM blocks
package tdm_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int NUM_CH = 4;
  localparam logic [1:0] LAST_CH = 2'd3;
endpackage

// File: rtl/tdm_channel_counter.sv
// tdm_channel_counter: 2-bit channel counter with load-1, clear, increment and terminal count
module tdm_channel_counter import tdm_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load1,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [1:0] o_cnt,
  output logic       o_tc
);
  logic [1:0] r_cnt;
  // clear wins over load-1, which wins over increment
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= 2'd0;
    else if (i_load1) r_cnt <= 2'd1;
    else if (i_inc) r_cnt <= r_cnt + 2'd1;
  end
  assign o_cnt = r_cnt;
  assign o_tc = r_cnt == LAST_CH;
endmodule

// File: rtl/tdm_demultiplexer1x4.sv
// tdm_demultiplexer1x4: distributes a TDM word stream onto four registered channels
module tdm_demultiplexer1x4 import tdm_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic [1:0]        sel_in,
  input  logic              frame_start,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              frame_done,
  output logic [1:0]        sel_cnt,
  output logic              sync_err
);
  state_t r_state;
  logic [WIDTH-1:0] r_s0, r_s1, r_s2;
  logic w_take, w_start, w_adv, w_tc, w_last;
  assign w_take = mode & din_valid;
  assign w_start = w_take & frame_start;
  assign w_adv = w_take & ~frame_start & (r_state == ST_RUN);
  assign w_last = w_adv & w_tc;
  tdm_channel_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .i_load1(w_start),
    .i_clr(~mode | w_last),
    .i_inc(w_adv),
    .o_cnt(sel_cnt),
    .o_tc(w_tc)
  );
  // explicit writes go straight to outputs; auto words collect in shadows until the last word publishes the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s0 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      ch_valid <= '0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ch_valid <= '0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
      if (!mode) begin
        r_state <= ST_IDLE;
        if (din_valid) begin
          if (sel_in == 2'd0) y0 <= din;
          if (sel_in == 2'd1) y1 <= din;
          if (sel_in == 2'd2) y2 <= din;
          if (sel_in == 2'd3) y3 <= din;
          ch_valid <= 4'b0001 << sel_in;
        end
      end else if (w_start) begin
        r_s0 <= din;
        sync_err <= (r_state == ST_RUN) && (sel_cnt != 2'd0);
        r_state <= ST_RUN;
      end else if (w_adv) begin
        if (sel_cnt == 2'd1) r_s1 <= din;
        if (sel_cnt == 2'd2) r_s2 <= din;
        if (w_tc) begin
          y0 <= r_s0;
          y1 <= r_s1;
          y2 <= r_s2;
          y3 <= din;
          ch_valid <= {NUM_CH{1'b1}};
          frame_done <= 1'b1;
          r_state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: doc/tdm_demultiplexer1x4.md
Name: tdm_demultiplexer1x4

Overview:
- Receive-side counterpart of the team's 4-to-1 multiplexer: takes one WIDTH-bit time-multiplexed stream and distributes it onto four registered channel outputs.
- Two modes:
  - Explicit: the channel is chosen per word by sel_in.
  - Auto TDM: an internal channel counter, aligned by frame_start, chooses the channel. Auto mode recovers frames produced by a mux driven by a free-running 2-bit select counter.
- Sits directly after the mux/serial link in lab datapaths and feeds per-channel consumers.

Parameters:
- WIDTH, 4, bit width of the data word and of each channel output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = explicit select, 1 = auto TDM
- din  input  WIDTH  multiplexed data word
- din_valid  input  1  din qualifies this cycle
- sel_in  input  2  target channel in explicit mode; ignored in auto mode
- frame_start  input  1  marks din as channel 0 of a new frame (auto mode only)
- y0, y1, y2, y3  output  WIDTH each  registered channel outputs
- ch_valid  output  4  one-hot, one-cycle strobe; bit k = yk updated this cycle
- frame_done  output  1  one-cycle pulse; a complete 4-word frame was published
- sel_cnt  output  2  current auto-mode channel counter
- sync_err  output  1  one-cycle pulse; frame_start arrived mid-frame

Behaviour:
- Reset, synchronous and active-high. Clears to 0:
  - y0..y3, ch_valid, frame_done, sync_err, sel_cnt, the shadow registers
  - state, which goes to IDLE.
  - Reset asserted mid-frame discards the partial frame with no pulses.
- Explicit mode (mode=0):
  - din_valid=1 writes din into y[sel_in] at the next edge; ch_valid[sel_in]=1 for that one cycle.
  - Latency: 1 clock.
  - While in explicit mode the auto machine is held in IDLE with sel_cnt=0.
- Auto mode (mode=1), FSM states IDLE and RUN:
  - Incoming words go to shadow registers s0..s3, not to the outputs.
  - IDLE:
    - din_valid and frame_start: write s0, sel_cnt becomes 1, go to RUN.
    - din_valid without frame_start: word dropped, no error.
  - RUN, din_valid=1 and frame_start=0:
    - Write s[sel_cnt] and increment sel_cnt.
    - On the write with sel_cnt=3: y0..y3 all load at once (the word in flight goes straight into y3); ch_valid=4'b1111; frame_done=1; sel_cnt wraps to 0; go to IDLE.
  - RUN, din_valid=1 and frame_start=1 with sel_cnt≠0:
    - sync_err=1.
    - Partial frame discarded, din written to s0, sel_cnt=1, stay in RUN.
  - din_valid=0: hold all state, no pulses. Gaps of any length between words are legal.
  - y0..y3 change only on frame completion, so consumers never see a mixed-frame set.
- Mode change:
  - Takes effect at the next edge.
  - 1→0 mid-frame: FSM returns to IDLE, sel_cnt=0, partial frame discarded. A din_valid in that same cycle is handled as explicit.
  - 0→1: starts in IDLE.
- frame_done and sync_err are never high in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package tdm_pkg holds:
  - state encoding: ST_IDLE=1'b0, ST_RUN=1'b1
  - constants: NUM_CH=4, LAST_CH=2'd3
- One natural sub-module: tdm_channel_counter. It is a 2-bit counter with load-1, clear and increment inputs, and a terminal-count output at 3. It is reused by the planned transmit-side TDM sequencer.
- The top level holds the FSM, the shadow registers and the output registers.

Test Plan:
1. Reset, then explicit mode. Send din=4'h5 with sel_in=2, then din=4'hA with sel_in=0.
   - y2=5, ch_valid=4'b0100 one cycle after the first word.
   - y0=A, ch_valid=4'b0001 one cycle after the second word.
   - y1=y3=0.
2. Auto mode. Send din 1,2,3,4 on consecutive valid cycles, frame_start on the first word.
   - y0..y3 stay 0 through the 3rd word.
   - After the 4th edge: y0..y3 = 1,2,3,4, ch_valid=4'b1111, frame_done=1 for exactly one cycle.
   - sel_cnt returns to 0.
3. Auto mode with gaps. Words 6,7,8,9 with din_valid low for 3 cycles between each.
   - Same result as scenario 2 with values 6..9.
   - No pulses during the gaps.
   - sel_cnt holds during the gaps.
4. Resync. Send 1,2 (frame_start on 1), then 5 with frame_start, then 6,7,8.
   - sync_err pulse at the edge that takes word 5.
   - Frame completes with y = 5,6,7,8.
   - frame_done only once.
5. Words outside a frame in auto IDLE. din_valid with din=F and no frame_start.
   - Outputs unchanged, no pulses, sel_cnt stays 0.
6. Interruptions mid-frame.
   - rst after 2 auto words: everything returns to 0.
   - Separately, mode 1→0 after 2 auto words, then explicit din=C with sel_in=3: y3=C, partial frame discarded, FSM in IDLE.
